// File: rtl/drain_collector4x4.sv
// drain_collector4x4: de-snakes 4x4 SE drain tokens into a ping-pong buffer and replays them row-major on a tagged valid/ready stream
module drain_collector4x4 #(
  parameter int ACCW = 40,
  parameter int SKIP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            out_phase,
  input  logic            se_valid,
  input  logic [ACCW-1:0] se_c,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [ACCW-1:0] m_data,
  output logic [1:0]      m_row,
  output logic [1:0]      m_col,
  output logic            m_last,
  output logic            overflow,
  output logic            err_short,
  input  logic            clr_err
);
  typedef enum logic [1:0] {IDLE, SKIP_S, CAP, WAIT_LOW} state_t;
  localparam int SW = SKIP > 1 ? $clog2(SKIP + 1) : 1;
  state_t st, st_n;
  logic [SW-1:0] sk, sk_n;
  logic [3:0] k, k_n, idx, addr;
  logic wr_bank, rd_bank, act, free, wr_full, wr_en, ovf_set, short_set, done;
  logic [1:0] full, full_n;
  logic [ACCW-1:0] mem [2][16];
  assign act = se_valid & out_phase;
  assign free = m_valid & m_ready & (idx == 4'd15);
  assign wr_full = full[wr_bank] & ~(free & (rd_bank == wr_bank));
  assign addr = {~k[3:2], k[2] ? k[1:0] : ~k[1:0]};
  assign m_valid = full[rd_bank];
  assign m_data = m_valid ? mem[rd_bank][idx] : '0;
  assign m_row = idx[3:2];
  assign m_col = idx[1:0];
  assign m_last = m_valid & (idx == 4'd15);
  always_comb begin
    st_n = st;
    k_n = k;
    sk_n = sk;
    wr_en = 1'b0;
    ovf_set = 1'b0;
    short_set = 1'b0;
    done = 1'b0;
    case (st)
      IDLE: if (act) begin
        if (wr_full) begin
          ovf_set = 1'b1;
          st_n = WAIT_LOW;
        end else begin
          sk_n = SW'(1);
          k_n = 4'd0;
          st_n = (SKIP == 1) ? CAP : SKIP_S;
        end
      end
      SKIP_S: if (!act) begin
        short_set = 1'b1;
        st_n = IDLE;
      end else begin
        sk_n = sk + SW'(1);
        st_n = (sk_n == SW'(SKIP)) ? CAP : SKIP_S;
      end
      CAP: if (act) begin
        wr_en = 1'b1;
        k_n = k + 4'd1;
        done = (k == 4'd15);
        st_n = done ? WAIT_LOW : CAP;
      end else begin
        short_set = 1'b1;
        st_n = IDLE;
      end
      default: st_n = act ? WAIT_LOW : IDLE;
    endcase
    full_n = full;
    if (free) full_n[rd_bank] = 1'b0;
    if (done) full_n[wr_bank] = 1'b1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= IDLE;
      k <= '0;
      sk <= '0;
      idx <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      full <= '0;
      overflow <= 1'b0;
      err_short <= 1'b0;
    end else begin
      st <= st_n;
      k <= k_n;
      sk <= sk_n;
      full <= full_n;
      if (done) wr_bank <= ~wr_bank;
      if (m_valid & m_ready) idx <= idx + 4'd1;
      if (free) rd_bank <= ~rd_bank;
      overflow <= ovf_set | (overflow & ~clr_err);
      err_short <= short_set | (err_short & ~clr_err);
    end
  always_ff @(posedge clk)
    if (wr_en) mem[wr_bank][addr] <= se_c;
endmodule
